// File: rtl/key_event_ctrl_if.sv
// Event stream between the key controller and its consumer: show-ahead
// valid/ready head of the event FIFO plus the sticky overflow flag.
interface key_event_ctrl_if #(
    parameter int NUM_KEYS = 4
);
    localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic [1:0]       evt_type;
    logic             evt_overflow;
    logic             clr_overflow;

    modport master (
        output evt_valid, evt_key, evt_type, evt_overflow,
        input  evt_ready, clr_overflow
    );

    modport slave (
        input  evt_valid, evt_key, evt_type, evt_overflow,
        output evt_ready, clr_overflow
    );
endinterface

// File: rtl/key_event_ctrl.sv
// Push-button debounce and event controller: one shared debounce/long-press
// step is time-multiplexed over all keys once per sample tick.
module key_event_ctrl #(
    parameter int NUM_KEYS       = 4,
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SAMPLE_US      = 1000,
    parameter int STABLE_SAMPLES = 20,
    parameter int LONG_SAMPLES   = 1000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    key_event_ctrl_if.master    evt
);
    localparam int SAMPLE_CYCLES = CLK_FREQ_HZ / 1_000_000 * SAMPLE_US;
    localparam int KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int PRE_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int CNT_W  = $clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_W = $clog2(LONG_SAMPLES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    typedef enum logic {IDLE, SCAN} state_t;

    logic [NUM_KEYS-1:0] sync_p0, sync_p1, snap;
    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    state_t              state, state_n;
    logic [KEY_W-1:0]    idx, idx_n;
    logic                step_en;

    logic [CNT_W-1:0]    cnt  [NUM_KEYS];
    logic [HOLD_W-1:0]   hold [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_done;

    logic                cur_lvl, nxt_lvl, nxt_ld, push;
    logic [CNT_W-1:0]    nxt_cnt;
    logic [HOLD_W-1:0]   nxt_hold;
    logic [1:0]          push_type;

    logic [KEY_W+1:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic                empty, full, pop, push_ok, overflow;

    // Input synchronizer, inverted so 1 means pressed
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= ~key_in;
            sync_p1 <= sync_p0;
        end
    end

    assign tick = (pre_cnt == PRE_W'(SAMPLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            snap    <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) snap <= sync_p1;
        end
    end

    // Scan sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        step_en = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end
            end
            SCAN: begin
                step_en = 1'b1;
                if (idx == KEY_W'(NUM_KEYS - 1)) state_n = IDLE;
                else                             idx_n   = idx + KEY_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Shared per-key step: a toggle and a long event never coincide
    always_comb begin
        cur_lvl   = key_level[idx];
        nxt_lvl   = cur_lvl;
        nxt_cnt   = cnt[idx];
        nxt_hold  = hold[idx];
        nxt_ld    = long_done[idx];
        push_type = EVT_NONE;
        if (snap[idx] == cur_lvl) begin
            nxt_cnt = '0;
        end else if (cnt[idx] + CNT_W'(1) == CNT_W'(STABLE_SAMPLES)) begin
            nxt_lvl = ~cur_lvl;
            nxt_cnt = '0;
            if (!cur_lvl) begin
                push_type = EVT_PRESS;
                nxt_hold  = '0;
                nxt_ld    = 1'b0;
            end else begin
                push_type = EVT_RELEASE;
            end
        end else begin
            nxt_cnt = cnt[idx] + CNT_W'(1);
        end
        if (cur_lvl && nxt_lvl && !long_done[idx]) begin
            nxt_hold = hold[idx] + HOLD_W'(1);
            if (hold[idx] + HOLD_W'(1) == HOLD_W'(LONG_SAMPLES)) begin
                push_type = EVT_LONG;
                nxt_ld    = 1'b1;
            end
        end
    end

    assign push = step_en && (push_type != EVT_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_level <= '0;
            long_done <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt[k]  <= '0;
                hold[k] <= '0;
            end
        end else if (step_en) begin
            key_level[idx] <= nxt_lvl;
            long_done[idx] <= nxt_ld;
            cnt[idx]       <= nxt_cnt;
            hold[idx]      <= nxt_hold;
        end
    end

    // Event FIFO: a pop frees the slot for a same-cycle push, no bypass
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && evt.evt_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            if (push && !push_ok)  overflow <= 1'b1;
            else if (evt.clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {idx, push_type};
    end

    assign evt.evt_valid    = !empty;
    assign {evt.evt_key, evt.evt_type} = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign evt.evt_overflow = overflow;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a tick-level behavioural model and
// hand-computed event sequences for each scenario.
module tb_key_event_ctrl;
    localparam int NK  = 4;
    localparam int SC  = 10;
    localparam int STB = 4;
    localparam int LNG = 20;
    localparam int FD  = 4;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level;

    key_event_ctrl_if #(.NUM_KEYS(NK)) dut_if ();

    key_event_ctrl #(
        .NUM_KEYS(NK), .CLK_FREQ_HZ(1_000_000), .SAMPLE_US(10),
        .STABLE_SAMPLES(STB), .LONG_SAMPLES(LNG), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level), .evt(dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    // Model state: cycle index since reset, synchronizer delay line,
    // per-key debounce state, per-key step results waiting for their slot.
    int            mc;
    int            gcyc;
    logic [NK-1:0] m_s1, m_s2, m_level;
    bit            m_lvl [NK];
    bit            m_ld  [NK];
    int            m_cnt [NK];
    int            m_hold[NK];
    bit            p_v   [NK];
    int            p_due [NK];
    bit            p_lvl [NK];
    int            p_evt [NK];
    int            mq_key[$];
    int            mq_type[$];
    bit            m_ovf;
    int            lk[$], lt[$], lc[$];

    always @(posedge clk) begin
        bit pop, push, tog;
        int pk, pt, ev;
        gcyc++;
        if (!rst && dut_if.evt_valid && dut_if.evt_ready) begin
            lk.push_back(int'(dut_if.evt_key));
            lt.push_back(int'(dut_if.evt_type));
            lc.push_back(gcyc);
        end
        if (rst) begin
            mc = 0; m_s1 = '0; m_s2 = '0; m_level = '0; m_ovf = 1'b0;
            mq_key.delete(); mq_type.delete();
            for (int k = 0; k < NK; k++) begin
                m_lvl[k] = 0; m_ld[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; p_v[k] = 0;
            end
        end else begin
            pop = (mq_key.size() > 0) && dut_if.evt_ready;
            if (pop) begin
                void'(mq_key.pop_front());
                void'(mq_type.pop_front());
            end
            push = 0; pk = 0; pt = 0;
            for (int k = 0; k < NK; k++) begin
                if (p_v[k] && p_due[k] == mc) begin
                    p_v[k] = 0;
                    m_level[k] = p_lvl[k];
                    if (p_evt[k] != 0) begin push = 1; pk = k; pt = p_evt[k]; end
                end
            end
            if (push && mq_key.size() < FD) begin
                mq_key.push_back(pk);
                mq_type.push_back(pt);
            end else if (push) begin
                m_ovf = 1'b1;
            end else if (dut_if.clr_overflow) begin
                m_ovf = 1'b0;
            end
            if (push && mq_key.size() <= FD && dut_if.clr_overflow && !(m_ovf && mq_key.size() == FD && !pop))
                m_ovf = m_ovf;
            if (mc % SC == SC - 1) begin
                for (int k = 0; k < NK; k++) begin
                    ev = 0; tog = 0;
                    if (m_s2[k] == m_lvl[k]) m_cnt[k] = 0;
                    else if (m_cnt[k] + 1 == STB) begin
                        tog = 1; m_cnt[k] = 0; m_lvl[k] = !m_lvl[k];
                        if (m_lvl[k]) begin ev = 1; m_hold[k] = 0; m_ld[k] = 0; end
                        else ev = 2;
                    end else m_cnt[k]++;
                    if (!tog && m_lvl[k] && !m_ld[k]) begin
                        m_hold[k]++;
                        if (m_hold[k] == LNG) begin ev = 3; m_ld[k] = 1; end
                    end
                    p_v[k] = 1; p_due[k] = mc + k + 1; p_lvl[k] = m_lvl[k]; p_evt[k] = ev;
                end
            end
            m_s2 = m_s1;
            m_s1 = ~key_in;
            mc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    task automatic compare();
        chk("key_level", int'(key_level), int'(m_level));
        chk("evt_valid", int'(dut_if.evt_valid), int'(mq_key.size() != 0));
        if (mq_key.size() != 0) begin
            chk("evt_key", int'(dut_if.evt_key), mq_key[0]);
            chk("evt_type", int'(dut_if.evt_type), mq_type[0]);
        end
        chk("evt_overflow", int'(dut_if.evt_overflow), int'(m_ovf));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (armed) compare();
        end
    endtask

    // Logged event i encoded as key*4+type; -1 when it never arrived
    task automatic chk_log(input string name, input int i, input int k, input int t);
        int a;
        a = (i < lk.size()) ? lk[i] * 4 + lt[i] : -1;
        chk(name, a, k * 4 + t);
    endtask

    task automatic chk_gap(input string name, input int i, input int exp);
        int a;
        a = (i + 1 < lc.size()) ? lc[i+1] - lc[i] : -1;
        chk(name, a, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bit got;
        rst = 1'b1; key_in = '1; dut_if.evt_ready = 1'b1; dut_if.clr_overflow = 1'b0;
        step(3);
        armed = 1'b1;
        chk("reset key_level", int'(key_level), 0);
        chk("reset evt_valid", int'(dut_if.evt_valid), 0);
        chk("reset evt_overflow", int'(dut_if.evt_overflow), 0);
        rst = 1'b0;
        step(20);

        // Reset while a scan is in flight with an event queued
        dut_if.evt_ready = 1'b0; key_in[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step(1);
            got = dut_if.evt_valid;
        end
        chk("midscan event pending", int'(got), 1);
        rst = 1'b1;
        step(1);
        chk("midscan rst key_level", int'(key_level), 0);
        chk("midscan rst evt_valid", int'(dut_if.evt_valid), 0);
        chk("midscan rst evt_overflow", int'(dut_if.evt_overflow), 0);
        rst = 1'b0; key_in = '1; dut_if.evt_ready = 1'b1;
        step(20);

        // Clean press/release of key 2
        b = lk.size();
        key_in[2] = 1'b0;
        step(80);
        chk("press2 key_level", int'(key_level), 4);
        step(20);
        key_in[2] = 1'b1;
        step(100);
        chk("release2 key_level", int'(key_level), 0);
        chk("press2 event count", lk.size() - b, 2);
        chk_log("press2 first", b, 2, 1);
        chk_log("press2 second", b + 1, 2, 2);

        // Bouncing key 0 must stay silent until it settles
        b = lk.size();
        for (int i = 0; i < 200; i++) begin
            key_in[0] = ((i / 7) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        chk("bounce silent", lk.size() - b, 0);
        key_in[0] = 1'b0;
        step(100);
        chk("bounce event count", lk.size() - b, 1);
        chk_log("bounce press", b, 0, 1);
        key_in[0] = 1'b1;
        step(100);
        chk_log("bounce release", b + 1, 0, 2);

        // Long press key 1
        b = lk.size();
        key_in[1] = 1'b0;
        step(300);
        key_in[1] = 1'b1;
        step(100);
        chk("long event count", lk.size() - b, 3);
        chk_log("long press", b, 1, 1);
        chk_log("long long", b + 1, 1, 3);
        chk_log("long release", b + 2, 1, 2);
        chk_gap("long spacing", b, SC * LNG);

        // Keys 0 and 3 together: scan order, three cycles apart
        b = lk.size();
        key_in[0] = 1'b0; key_in[3] = 1'b0;
        step(60);
        chk("simul event count", lk.size() - b, 2);
        chk_log("simul first", b, 0, 1);
        chk_log("simul second", b + 1, 3, 1);
        chk_gap("simul spacing", b, 3);
        key_in = '1;
        step(60);

        // Overflow: four presses fill the FIFO, two releases are dropped
        b = lk.size();
        dut_if.evt_ready = 1'b0;
        key_in = '0;
        step(80);
        key_in[0] = 1'b1; key_in[1] = 1'b1;
        step(70);
        chk("overflow set", int'(dut_if.evt_overflow), 1);
        chk("overflow head valid", int'(dut_if.evt_valid), 1);
        dut_if.clr_overflow = 1'b1;
        step(1);
        dut_if.clr_overflow = 1'b0;
        chk("overflow cleared", int'(dut_if.evt_overflow), 0);
        dut_if.evt_ready = 1'b1;
        step(10);
        chk("drain count", lk.size() - b, 4);
        chk_log("drain 0", b, 0, 1);
        chk_log("drain 1", b + 1, 1, 1);
        chk_log("drain 2", b + 2, 2, 1);
        chk_log("drain 3", b + 3, 3, 1);
        chk("drained evt_valid", int'(dut_if.evt_valid), 0);
        key_in = '1;
        step(80);
        chk("final key_level", int'(key_level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Debounce-and-event controller for the board's push-button keys. Samples all raw active-low key inputs on a shared millisecond tick and time-shares one debounce/long-press update datapath across them with a per-tick scan sequencer. Emits press, release and long-press events through a small valid/ready event FIFO to the LED/application logic, and provides the debounced key levels directly.

## Interface
- `NUM_KEYS`, 4: number of keys, 1–16.
- `CLK_FREQ_HZ`, 50_000_000: clk frequency.
- `SAMPLE_US`, 1000: sample tick period in µs. `SAMPLE_CYCLES = CLK_FREQ_HZ/1_000_000*SAMPLE_US`. Must satisfy `SAMPLE_CYCLES >= NUM_KEYS+2`.
- `STABLE_SAMPLES`, 20: consecutive differing samples needed to accept a level change, ≥1.
- `LONG_SAMPLES`, 1000: pressed samples after the press event before a long event, ≥1.
- `FIFO_DEPTH`, 8: event FIFO depth, power of two, ≥2.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in NUM_KEYS: raw asynchronous keys, 0 = pressed.
- `key_level` out NUM_KEYS: debounced level, 1 = pressed.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer pops the head when `evt_valid & evt_ready`.
- `evt_key` out clog2(NUM_KEYS) (min 1): key index of the head event.
- `evt_type` out 2: 01 press, 10 release, 11 long; 00 never stored.
- `evt_overflow` out 1: sticky, set when an event is dropped.
- `clr_overflow` in 1: clears `evt_overflow`. Set wins over clear in the same cycle.

## Operation
- Synchronizer: 2-FF per key, inverted, so `s[k]`=1 means pressed. Reset value 0.
- Prescaler: counts 0..SAMPLE_CYCLES-1 and wraps. `tick` is asserted when count == SAMPLE_CYCLES-1.
- Sequencer FSM:
  - IDLE: on tick, `idx`←0 and go to SCAN.
  - SCAN: process key `idx` in one cycle, then `idx`++. After processing NUM_KEYS-1, return to IDLE.
  - Snapshot: `s` is captured into `snap` on the tick cycle. All keys in one scan use the same snapshot.
- Per-key state: `cnt[k]` (debounce, clog2(STABLE_SAMPLES+1) bits), `hold[k]` (clog2(LONG_SAMPLES+1) bits), `long_done[k]`.
- Step for key k (shared logic):
  - If `snap[k]==key_level[k]`: `cnt[k]`←0.
  - Else if `cnt[k]+1==STABLE_SAMPLES`: toggle `key_level[k]` and clear `cnt[k]`.
    - New level 1: emit press, `hold[k]`←0, `long_done[k]`←0.
    - New level 0: emit release.
  - Else: `cnt[k]`++.
  - Long press: when level is 1, no toggle this step, and `!long_done[k]`, increment `hold[k]`. When `hold[k]+1==LONG_SAMPLES`, emit long and set `long_done[k]`. At most one long event per press.
  - At most one event per step. A release is always emitted, even after a long event.
- Event FIFO: show-ahead, at most one write per cycle.
  - A write is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `evt_overflow` is set.
  - Simultaneous push and pop on an empty FIFO: the push is stored and `evt_valid` rises the next cycle (no bypass).
  - Events are delivered in strict generation order: ascending key index within a scan, then by scan.
- Reset (any cycle, including mid-scan):
  - FSM→IDLE; prescaler, `snap`, `cnt`, `hold`, `long_done` → 0.
  - FIFO emptied; `key_level`=0, `evt_valid`=0, `evt_key`=0, `evt_type`=0, `evt_overflow`=0.

## Timing
- First tick is at cycle SAMPLE_CYCLES-1 after reset deasserts. Ticks then repeat every SAMPLE_CYCLES cycles.
- Key k is processed k+1 cycles after the tick cycle. `key_level[k]` changes at the end of that cycle.
- An event written in the step cycle is visible on `evt_valid` one cycle later (FIFO previously empty).
- Input-to-snapshot latency: 2 synchronizer cycles plus up to SAMPLE_CYCLES.
- Press acceptance: STABLE_SAMPLES consecutive ticks with `snap` differing from `key_level`.
- A scan never overlaps the next tick, guaranteed by the parameter constraint. No tick is lost.

## Test plan
Parameters for all scenarios: CLK_FREQ_HZ=1_000_000, SAMPLE_US=10 (10 cycles), STABLE_SAMPLES=4, LONG_SAMPLES=20, FIFO_DEPTH=4, NUM_KEYS=4.
- Reset: hold `rst` 3 cycles with keys idle → `key_level`=0000, `evt_valid`=0, `evt_overflow`=0. Assert `rst` mid-scan with an event pending → same state next cycle, FIFO empty.
- Clean press/release key 2: `key_in[2]`=0 for 100 cycles, then 1 → `key_level`=0100 on the 4th tick after the snapshot sees 1. Exactly one {2,01}, later one {2,10}. No long event.
- Bounce: toggle `key_in[0]` every 7 cycles for 200 cycles, then hold 0 → no event during bouncing. Exactly one {0,01} 4 ticks after the bouncing stops.
- Long press key 1: hold 0 for 30 ticks, then release → {1,01}, then {1,11} 20 ticks later, then {1,10}. Exactly three events.
- Simultaneous/order: press keys 0 and 3 on the same cycle with `evt_ready`=1 → {0,01} then {3,01}, 3 cycles apart.
- Overflow: `evt_ready`=0 while generating 6 events → FIFO holds the first 4 and `evt_overflow`=1. Pulse `clr_overflow` → 0. Drain → the 4 events arrive in order.
